// File: rtl/bcd_sexa_timer.sv
// Chain of DIGITS/2 BCD fields counting 00-59, with up/down, preset load, wrap/saturate and terminal count.
// One-cycle step latency; carry/borrow ripples combinationally through all digits.
module bcd_sexa_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                en_i,
  input  logic                dir_i,
  input  logic                wrap_en_i,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  output logic [4*DIGITS-1:0] value_o,
  output logic                tc_o,
  output logic                load_err_o,
  output logic                at_zero_o,
  output logic                at_max_o
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] value_q, value_d, step_val;
  logic         tc_q, tc_d;
  logic         load_err_q, load_err_d;
  logic         load_ok, at_max, at_zero, limit;
  logic         cy;
  logic [3:0]   dig, lim, ldig;

  // Ripple step plus per-digit limit checks; even digits are ones (0-9), odd are tens (0-5).
  always_comb begin
    step_val = value_q;
    cy       = 1'b1;
    at_max   = 1'b1;
    load_ok  = 1'b1;
    dig      = 4'd0;
    lim      = 4'd0;
    ldig     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig  = value_q[4*i +: 4];
      ldig = load_val_i[4*i +: 4];
      lim  = (i % 2 == 1) ? 4'd5 : 4'd9;
      if (dig != lim) at_max = 1'b0;
      if (ldig > lim) load_ok = 1'b0;
      if (cy) begin
        if (!dir_i) begin
          if (dig == lim) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = dig + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*i +: 4] = lim;
          end else begin
            step_val[4*i +: 4] = dig - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
  end

  assign at_zero = (value_q == '0);
  assign limit   = dir_i ? at_zero : at_max;

  always_comb begin
    value_d    = value_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (clear_i) begin
      value_d = '0;
    end else if (load_i) begin
      if (load_ok) value_d = load_val_i;
      else         load_err_d = 1'b1;
    end else if (tick_i && en_i) begin
      // Saturation blocks the update but still reports the terminal count.
      tc_d = limit;
      if (!limit || wrap_en_i) value_d = step_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign value_o    = value_q;
  assign tc_o       = tc_q;
  assign load_err_o = load_err_q;
  assign at_zero_o  = at_zero;
  assign at_max_o   = at_max;

endmodule
